// File: rtl/wb_stage_pipe_if.sv
// rtl/wb_stage_pipe_if.sv - MEM-to-WB instruction bus and register-file write port
// Forwarding signals exist only when WB_FWD_EN is defined.
interface wb_stage_pipe_if #(
  parameter int WORD_SIZE   = 32,
  parameter int REG_WR_SIZE = 5,
  parameter int CNT_BITS    = 32
);
  localparam int OFS_BITS = $clog2(WORD_SIZE / 8);

  logic                   i_valid;
  logic                   o_ready;
  logic                   i_stall;
  logic                   i_flush;
  logic [1:0]             i_sel;
  logic [WORD_SIZE-1:0]   i_alu;
  logic [WORD_SIZE-1:0]   i_mem;
  logic [WORD_SIZE-1:0]   i_pc4;
  logic [WORD_SIZE-1:0]   i_imm;
  logic [2:0]             i_funct3;
  logic [OFS_BITS-1:0]    i_addr_lsb;
  logic                   i_rf_we;
  logic [REG_WR_SIZE-1:0] i_rd;
  logic                   o_rf_we;
  logic [REG_WR_SIZE-1:0] o_wr_reg;
  logic [WORD_SIZE-1:0]   o_data_out;
  logic                   o_misalign;
  logic [CNT_BITS-1:0]    o_retire_cnt;
`ifdef WB_FWD_EN
  logic                   o_fwd_valid;
  logic [REG_WR_SIZE-1:0] o_fwd_reg;
  logic [WORD_SIZE-1:0]   o_fwd_data;
`endif

  modport slave (
    input  i_valid, i_stall, i_flush, i_sel, i_alu, i_mem, i_pc4, i_imm,
           i_funct3, i_addr_lsb, i_rf_we, i_rd,
`ifdef WB_FWD_EN
    output o_fwd_valid, o_fwd_reg, o_fwd_data,
`endif
    output o_ready, o_rf_we, o_wr_reg, o_data_out, o_misalign, o_retire_cnt
  );

  modport master (
    output i_valid, i_stall, i_flush, i_sel, i_alu, i_mem, i_pc4, i_imm,
           i_funct3, i_addr_lsb, i_rf_we, i_rd,
`ifdef WB_FWD_EN
    input  o_fwd_valid, o_fwd_reg, o_fwd_data,
`endif
    input  o_ready, o_rf_we, o_wr_reg, o_data_out, o_misalign, o_retire_cnt
  );
endinterface

// File: rtl/wb_stage_pipe.sv
// rtl/wb_stage_pipe.sv - RISC-V write-back stage: MEM/WB register, load extension, retire counter
// Define WB_FWD_EN to add the o_fwd_* bypass outputs.
module wb_stage_pipe #(
  parameter int WORD_SIZE   = 32,
  parameter int REG_WR_SIZE = 5,
  parameter int CNT_BITS    = 32
) (
  input logic            i_clk,
  input logic            i_rst_n,
  wb_stage_pipe_if.slave bus
);
  localparam int OFS_BITS = $clog2(WORD_SIZE / 8);

  logic                   valid_q;
  logic [1:0]             sel_q;
  logic [WORD_SIZE-1:0]   alu_q;
  logic [WORD_SIZE-1:0]   mem_q;
  logic [WORD_SIZE-1:0]   pc4_q;
  logic [WORD_SIZE-1:0]   imm_q;
  logic [2:0]             funct3_q;
  logic [OFS_BITS-1:0]    ofs_q;
  logic                   rf_we_q;
  logic [REG_WR_SIZE-1:0] rd_q;
  logic [CNT_BITS-1:0]    cnt_q;

  logic                   take;
  logic                   misalign;
  logic                   retire;
  logic [WORD_SIZE-1:0]   shifted;
  logic [WORD_SIZE-1:0]   load_val;
  logic                   load_mis;
  logic [WORD_SIZE-1:0]   wb_data;

  assign take = bus.i_valid && !bus.i_flush && !bus.i_stall;

  // Payload registers only load on an accepted instruction so bubbles keep the last write visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      sel_q    <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      pc4_q    <= '0;
      imm_q    <= '0;
      funct3_q <= '0;
      ofs_q    <= '0;
      rf_we_q  <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q <= take;
      if (take) begin
        sel_q    <= bus.i_sel;
        alu_q    <= bus.i_alu;
        mem_q    <= bus.i_mem;
        pc4_q    <= bus.i_pc4;
        imm_q    <= bus.i_imm;
        funct3_q <= bus.i_funct3;
        ofs_q    <= bus.i_addr_lsb;
        rf_we_q  <= bus.i_rf_we;
        rd_q     <= bus.i_rd;
      end
      if (retire) begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
    end
  end

  // Unknown load codes fall through to the full-word default, which needs offset zero.
  always_comb begin
    shifted  = mem_q >> {ofs_q, 3'b000};
    load_val = mem_q;
    load_mis = (ofs_q != '0);
    case (funct3_q)
      3'b000: begin
        load_val = WORD_SIZE'($signed(shifted[7:0]));
        load_mis = 1'b0;
      end
      3'b100: begin
        load_val = WORD_SIZE'(shifted[7:0]);
        load_mis = 1'b0;
      end
      3'b001: begin
        load_val = WORD_SIZE'($signed(shifted[15:0]));
        load_mis = ofs_q[0];
      end
      3'b101: begin
        load_val = WORD_SIZE'(shifted[15:0]);
        load_mis = ofs_q[0];
      end
      3'b010: begin
        if (WORD_SIZE == 64) begin
          load_val = WORD_SIZE'($signed(shifted[31:0]));
          load_mis = (ofs_q[1:0] != 2'b00);
        end
      end
      3'b110: begin
        if (WORD_SIZE == 64) begin
          load_val = WORD_SIZE'(shifted[31:0]);
          load_mis = (ofs_q[1:0] != 2'b00);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wb_data = imm_q;
    case (sel_q)
      2'b00:   wb_data = alu_q;
      2'b01:   wb_data = load_val;
      2'b10:   wb_data = pc4_q;
      default: wb_data = imm_q;
    endcase
  end

  assign misalign = valid_q && (sel_q == 2'b01) && load_mis;
  assign retire   = valid_q && !misalign;

  assign bus.o_ready      = !bus.i_stall;
  assign bus.o_rf_we      = valid_q && rf_we_q && (rd_q != '0) && !misalign;
  assign bus.o_wr_reg     = rd_q;
  assign bus.o_data_out   = wb_data;
  assign bus.o_misalign   = misalign;
  assign bus.o_retire_cnt = cnt_q;

`ifdef WB_FWD_EN
  assign bus.o_fwd_valid = bus.o_rf_we;
  assign bus.o_fwd_reg   = rd_q;
  assign bus.o_fwd_data  = wb_data;
`endif
endmodule

// File: tb/tb_wb_stage_pipe.sv
// tb/tb_wb_stage_pipe.sv - scoreboard bench for wb_stage_pipe (32-bit/4-bit counter and 64-bit instances)
module tb_wb_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_pipe_if #(.WORD_SIZE(32), .REG_WR_SIZE(5), .CNT_BITS(4))  a_if ();
  wb_stage_pipe_if #(.WORD_SIZE(64), .REG_WR_SIZE(5), .CNT_BITS(32)) b_if ();

  wb_stage_pipe #(.WORD_SIZE(32), .REG_WR_SIZE(5), .CNT_BITS(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(a_if)
  );
  wb_stage_pipe #(.WORD_SIZE(64), .REG_WR_SIZE(5), .CNT_BITS(32)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b_if)
  );

  typedef struct {
    logic        we;
    logic        mis;
    logic [4:0]  wreg;
    logic [31:0] data;
    logic        chk_data;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  m_cnt;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  localparam logic [31:0] MEMW = 32'h80FF_7F01;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of MEM-stage input and queue the response expected after the next edge.
  task automatic issue(input logic v, input logic st, input logic fl, input logic [1:0] sel,
                       input logic [31:0] val, input logic [2:0] f3, input logic [1:0] ofs,
                       input logic we, input logic [4:0] rd, input logic [31:0] exp_data,
                       input logic exp_mis);
    exp_t e;
    logic tk;
    @(negedge clk);
    a_if.i_valid    = v;
    a_if.i_stall    = st;
    a_if.i_flush    = fl;
    a_if.i_sel      = sel;
    a_if.i_alu      = (sel == 2'b00) ? val : 32'h1111_1111;
    a_if.i_mem      = (sel == 2'b01) ? val : 32'h2222_2222;
    a_if.i_pc4      = (sel == 2'b10) ? val : 32'h3333_3333;
    a_if.i_imm      = (sel == 2'b11) ? val : 32'h4444_4444;
    a_if.i_funct3   = f3;
    a_if.i_addr_lsb = ofs;
    a_if.i_rf_we    = we;
    a_if.i_rd       = rd;
    tk         = v && !st && !fl;
    e.mis      = tk && (sel == 2'b01) && exp_mis;
    e.we       = tk && we && (rd != 5'd0) && !e.mis;
    if (tk) begin
      m_reg  = rd;
      m_data = exp_data;
    end
    e.wreg     = m_reg;
    e.data     = m_data;
    e.chk_data = !e.mis;
    e.cnt      = m_cnt;
    if (tk && !e.mis) m_cnt = m_cnt + 4'd1;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic b_run(input logic [2:0] f3, input logic [2:0] ofs, input logic [63:0] mem,
                       input logic [63:0] exp_data, input logic exp_mis);
    @(negedge clk);
    b_if.i_valid = 1'b1; b_if.i_sel = 2'b01; b_if.i_mem = mem; b_if.i_funct3 = f3;
    b_if.i_addr_lsb = ofs; b_if.i_rf_we = 1'b1; b_if.i_rd = 5'd7;
    @(posedge clk);
    #1;
    chk("b_misalign", b_if.o_misalign, exp_mis);
    chk("b_rf_we", b_if.o_rf_we, !exp_mis);
    if (!exp_mis) chk("b_data", b_if.o_data_out, exp_data);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rf_we", a_if.o_rf_we, mon_e.we);
        chk("misalign", a_if.o_misalign, mon_e.mis);
        chk("wr_reg", a_if.o_wr_reg, mon_e.wreg);
        if (mon_e.chk_data) chk("data_out", a_if.o_data_out, mon_e.data);
        chk("retire_cnt", a_if.o_retire_cnt, mon_e.cnt);
`ifdef WB_FWD_EN
        chk("fwd_valid", a_if.o_fwd_valid, mon_e.we);
        chk("fwd_reg", a_if.o_fwd_reg, mon_e.wreg);
        if (mon_e.chk_data) chk("fwd_data", a_if.o_fwd_data, mon_e.data);
`endif
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m_cnt = '0; m_reg = '0; m_data = '0;
    a_if.i_valid = 0; a_if.i_stall = 0; a_if.i_flush = 0; a_if.i_sel = 0; a_if.i_alu = 0;
    a_if.i_mem = 0; a_if.i_pc4 = 0; a_if.i_imm = 0; a_if.i_funct3 = 0; a_if.i_addr_lsb = 0;
    a_if.i_rf_we = 0; a_if.i_rd = 0;
    b_if.i_valid = 0; b_if.i_stall = 0; b_if.i_flush = 0; b_if.i_sel = 0; b_if.i_alu = 0;
    b_if.i_mem = 0; b_if.i_pc4 = 0; b_if.i_imm = 0; b_if.i_funct3 = 0; b_if.i_addr_lsb = 0;
    b_if.i_rf_we = 0; b_if.i_rd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", a_if.o_rf_we, 1'b0);
    chk("rst_wr_reg", a_if.o_wr_reg, 5'd0);
    chk("rst_data", a_if.o_data_out, 32'd0);
    chk("rst_misalign", a_if.o_misalign, 1'b0);
    chk("rst_cnt", a_if.o_retire_cnt, 4'd0);
    chk("ready_idle", a_if.o_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 0, 0, 2'b00, 32'h0000_1234, 3'b000, 2'd0, 1, 5'd5,  32'h0000_1234, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b000, 2'd3, 1, 5'd6,  32'hFFFF_FF80, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b100, 2'd3, 1, 5'd7,  32'h0000_0080, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b001, 2'd2, 1, 5'd8,  32'hFFFF_80FF, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b101, 2'd0, 1, 5'd9,  32'h0000_7F01, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b001, 2'd1, 1, 5'd10, 32'h0,         1);
    issue(1, 0, 0, 2'b01, MEMW,          3'b010, 2'd2, 1, 5'd11, 32'h0,         1);
    issue(1, 0, 0, 2'b01, MEMW,          3'b010, 2'd0, 1, 5'd12, 32'h80FF_7F01, 0);
    issue(1, 0, 0, 2'b00, 32'hDEAD_BEEF, 3'b000, 2'd0, 1, 5'd0,  32'hDEAD_BEEF, 0);
    issue(1, 0, 0, 2'b10, 32'h0000_0104, 3'b000, 2'd0, 1, 5'd13, 32'h0000_0104, 0);
    issue(1, 1, 0, 2'b11, 32'hABCD_E000, 3'b000, 2'd0, 1, 5'd14, 32'hABCD_E000, 0);
    #1 chk("ready_stall", a_if.o_ready, 1'b0);
    issue(1, 0, 0, 2'b11, 32'hABCD_E000, 3'b000, 2'd0, 1, 5'd14, 32'hABCD_E000, 0);
    issue(1, 0, 1, 2'b00, 32'h0000_5555, 3'b000, 2'd0, 1, 5'd15, 32'h0000_5555, 0);
    issue(1, 1, 1, 2'b00, 32'h0000_6666, 3'b000, 2'd0, 1, 5'd16, 32'h0000_6666, 0);
    issue(1, 0, 0, 2'b00, 32'h0000_0077, 3'b000, 2'd0, 0, 5'd3,  32'h0000_0077, 0);
    issue(0, 0, 0, 2'b00, 32'h0000_0088, 3'b000, 2'd0, 1, 5'd4,  32'h0000_0088, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b100, 2'd1, 1, 5'd1,  32'h0000_007F, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b000, 2'd0, 1, 5'd2,  32'h0000_0001, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b101, 2'd2, 1, 5'd3,  32'h0000_80FF, 0);
    issue(1, 0, 0, 2'b01, MEMW,          3'b001, 2'd0, 1, 5'd4,  32'h0000_7F01, 0);
    issue(1, 0, 0, 2'b00, 32'h0000_0099, 3'b001, 2'd1, 1, 5'd5,  32'h0000_0099, 0);
    for (int i = 0; i < 18; i++) begin
      issue(1, 0, 0, 2'b00, 32'(i * 3 + 100), 3'b000, 2'd0, 1, 5'(i % 31 + 1), 32'(i * 3 + 100), 0);
    end
    issue(0, 0, 0, 2'b00, 32'h0, 3'b000, 2'd0, 0, 5'd0, 32'h0, 0);
    drain();

    // An accepted instruction is visible on the write port when reset hits mid-cycle.
    @(negedge clk);
    a_if.i_valid = 1; a_if.i_stall = 0; a_if.i_flush = 0; a_if.i_sel = 2'b00;
    a_if.i_alu = 32'h0000_CAFE; a_if.i_rf_we = 1; a_if.i_rd = 5'd9;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_rf_we", a_if.o_rf_we, 1'b0);
    chk("midrst_wr_reg", a_if.o_wr_reg, 5'd0);
    chk("midrst_data", a_if.o_data_out, 32'd0);
    chk("midrst_misalign", a_if.o_misalign, 1'b0);
    chk("midrst_cnt", a_if.o_retire_cnt, 4'd0);
    @(negedge clk);
    a_if.i_valid = 0;
    rst_n = 1'b1;
    m_cnt = '0; m_reg = '0; m_data = '0;
    issue(1, 0, 0, 2'b00, 32'h0000_0042, 3'b000, 2'd0, 1, 5'd2, 32'h0000_0042, 0);
    issue(0, 0, 0, 2'b00, 32'h0, 3'b000, 2'd0, 0, 5'd0, 32'h0, 0);
    drain();

    b_run(3'b110, 3'd4, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, 0);
    b_run(3'b010, 3'd4, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    b_run(3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
    b_run(3'b011, 3'd4, 64'h0123_4567_89AB_CDEF, 64'h0, 1);
    b_run(3'b101, 3'd6, 64'h8765_0000_0000_0000, 64'h0000_0000_0000_8765, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised RISC-V write-back stage. It registers the MEM/WB pipeline boundary (1-cycle latency) and selects the write-back source from ALU, memory, PC+4 or immediate.
- Sign- or zero-extends sub-word loads by byte offset, suppresses writes to x0, and flags misaligned loads.
- Counts retired instructions.
- Sits between the memory-access stage and the register-file write port.

Parameters:
- WORD_SIZE, 32, datapath width; legal values 32 or 64.
- REG_WR_SIZE, 5, register-file address width.
- CNT_BITS, 32, width of the retire counter.
- OFS_BITS (localparam), log2(WORD_SIZE/8), byte-offset width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  MEM stage presents an instruction.
- o_ready  out  1  WB accepts this cycle; equals !i_stall.
- i_stall  in  1  hazard stall: insert bubble, do not consume.
- i_flush  in  1  kill the instruction being captured.
- i_sel  in  2  source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- i_alu  in  WORD_SIZE  ALU result.
- i_mem  in  WORD_SIZE  raw aligned memory word.
- i_pc4  in  WORD_SIZE  PC+4.
- i_imm  in  WORD_SIZE  immediate (LUI).
- i_funct3  in  3  load type.
- i_addr_lsb  in  OFS_BITS  load byte offset.
- i_rf_we  in  1  instruction writes rd.
- i_rd  in  REG_WR_SIZE  destination register.
- o_rf_we  out  1  register-file write enable.
- o_wr_reg  out  REG_WR_SIZE  register-file write address.
- o_data_out  out  WORD_SIZE  register-file write data.
- o_misalign  out  1  1-cycle pulse: misaligned load retired (write suppressed).
- o_retire_cnt  out  CNT_BITS  retired-instruction count.

Behaviour:
- **Reset (i_rst_n low, asynchronous):**
  - Internal valid cleared; all pipeline registers cleared.
  - Outputs: o_rf_we=0, o_wr_reg=0, o_data_out=0, o_misalign=0, o_retire_cnt=0.
  - Reset mid-operation discards the in-flight instruction with no write.
- **Capture, each rising edge, priority order:**
  - i_flush → valid_q=0.
  - else i_stall → valid_q=0 (bubble); input not consumed, MEM holds it.
  - else valid_q=i_valid and all inputs are latched.
- Flush with stall gives a bubble; flush wins over everything.
- **Latency:** the instruction accepted at edge N drives o_rf_we/o_wr_reg/o_data_out during cycle N+1. There are no double writes, because a stall always produces a bubble.
- **Data selection** uses the registered values. For sel=01 the load extension below is applied; other selects pass the value through unchanged.
- **Load extension** (b = offset×8):
  - 000 LB: sign-extend byte at b.
  - 001 LH: sign-extend half at b.
  - 100 LBU: zero-extend byte at b.
  - 101 LHU: zero-extend half at b.
  - 010 LW: if WORD_SIZE=32, whole word; if 64, sign-extend word at b.
  - 110 LWU (64 only): zero-extend word at b.
  - 011 LD (64 only): whole word.
  - Any other code: treated as a full-word load.
- **Alignment rule:** half needs offset[0]=0; word needs offset[1:0]=0; full-word needs offset=0.
- **Misaligned load** (sel=01 only):
  - o_rf_we=0 and o_misalign=1 for that cycle.
  - o_data_out still shows the extracted value; it is don't-care for verification.
- **Write enable:** o_rf_we = valid_q & rf_we_q & (rd_q≠0) & !misalign. If rd_q==0, o_wr_reg still shows 0 and no write occurs.
- **When valid_q=0:** o_rf_we=0 and o_misalign=0; o_wr_reg and o_data_out hold their last values.
- **Retire counter:**
  - Increments by 1 at the edge ending each cycle with valid_q=1 and no misalign. This includes stores and branches (rf_we=0).
  - Wraps from 2^CNT_BITS−1 to 0.

Optional Feature:
- **Macro:** WB_FWD_EN.
- **When defined**, adds three outputs:
  - o_fwd_valid (1): equals o_rf_we, same cycle.
  - o_fwd_reg (REG_WR_SIZE): the write-back register address.
  - o_fwd_data (WORD_SIZE): the write-back data.
  - These let the EX stage bypass the register file in the write cycle.
- **When undefined**, these ports and their logic are absent, and all other behaviour is identical.

Test Plan:
- Reset released; valid sel=00, alu=0x0000_1234, rd=5, we=1 at edge 1 → cycle 2: o_rf_we=1, o_wr_reg=5, o_data_out=0x0000_1234; o_retire_cnt=1 after edge 2.
- mem=0x80FF_7F01, sel=01: LB off=3 → 0xFFFF_FF80; LBU off=3 → 0x0000_0080; LH off=2 → 0xFFFF_80FF; LHU off=0 → 0x0000_7F01.
- LH off=1 or LW off=2 → o_misalign=1 for 1 cycle, o_rf_we=0, counter unchanged.
- rd=0, we=1, alu=0xDEAD_BEEF → o_rf_we=0; counter increments.
- Back-to-back instructions A,B with i_stall high one cycle between them → A writes, bubble cycle (o_rf_we=0), B writes once. i_flush with valid → no write, no count. Reset asserted mid-stream → all outputs 0 immediately.
- CNT_BITS=4: 16 retires → counter wraps to 0. WORD_SIZE=64: LWU off=4, mem=0xFFFF_FFFF_0000_0000 → 0x0000_0000_FFFF_FFFF; LW same → 0xFFFF_FFFF_FFFF_FFFF. With WB_FWD_EN: o_fwd_* match the write port each cycle.
